shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle shift/rotate controller for the ALU datapath. Accepts a one-shot start with opcode, 32-bit operand and shift amount, then steps an internal working register through SHR, SHRA, SHL, ROR or ROL over several clocks instead of one deep combinational pass. It raises a one-cycle done pulse with the result held stable. It sits beside the ALU and is started by the control unit's shift/rotate microstates.

## Interface
- DATA_W, 32, operand/result width (fixed at 32; other values unsupported)
- clock  in  1  system clock, rising edge
- clear  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when ready=1
- op  in  3  operation: 0 SHR, 1 SHRA, 2 SHL, 3 ROR, 4 ROL, 5–7 illegal
- A  in  32  operand, captured on accepted start
- B  in  32  shift amount, captured on accepted start
- ready  out  1  block can accept start (IDLE or DONE)
- busy  out  1  high in SHIFT state
- done  out  1  one-cycle pulse: result valid
- result  out  32  working register; holds last result until next accepted start
- illegal  out  1  high with done when the captured op was 5–7

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE, result=0, done=0, busy=0, illegal=0, ready=1.
- Accept: start=1 and ready=1 at an edge → result←A, op latched, count←N.
- Count N rules:
  - ROR/ROL: N = B[4:0]; rotation is mod 32.
  - SHR/SHRA/SHL: N = min(B, 32), unsigned over all 32 bits of B.
  - Illegal op: N = 0 and illegal set.
- If N=0 → DONE directly; else → SHIFT.
- SHIFT: each edge applies one step of k bits to result and does count←count−k, where k = min(count, STEP).
  - STEP = 1 by default; see Configuration.
  - Go to DONE on the edge where count reaches 0.
- Step semantics:
  - SHR: zero fill from MSB.
  - SHRA: replicate bit 31.
  - SHL: zero fill from LSB.
  - ROR: bit 0 → bit 31.
  - ROL: bit 31 → bit 0.
- A shift of 32 yields 0 (SHR/SHL) or 32 copies of A[31] (SHRA).
- DONE: done=1 for exactly one cycle; illegal reflects the latched op.
  - Next edge → IDLE, or → a new accept if start=1 (back-to-back).
- start while busy: ignored, no queuing, no side effect.
- A and B may change freely after acceptance.

## Timing
- Steps S = ceil(N/STEP). done is high in the cycle following edge S+1 counted from the accept edge. N=0 gives done one cycle after accept.
- Max latency: 33 cycles with STEP=1; 5 cycles with STEP=8.
- busy is high from the cycle after accept until done's cycle (exclusive), and low when N=0.
- ready = ~busy. It is registered from state, not combinational from start.
- result changes only on accept and on SHIFT edges. It is stable during DONE and IDLE.
- clear mid-operation: next edge → IDLE with all outputs at reset values. The partial result is discarded and no done is issued.
- clear and start in the same cycle: clear wins and start is dropped.

## Configuration
- SHIFT_MULTI_STEP_EN defined: STEP = 8. The step unit supports k ∈ {1..8}, selected from min(count, 8).
- SHIFT_MULTI_STEP_EN undefined: STEP = 1. The step unit only implements k = 1. Function is identical in both cases; only latency differs.

## Structure
- Package shift_pkg holds:
  - op encodings (OP_SHR…OP_ROL)
  - state enum (ST_IDLE, ST_SHIFT, ST_DONE)
  - MAX_SHIFT=32
  - STEP constant derived from the macro
- Sub-module shift_step: combinational, ports (op, value[31:0], k[3:0]) → value_out[31:0]. It applies one k-bit step.
- shift_sequencer owns the FSM, the count register, saturation of N, and the result register.

## Test plan
- ROR A=0x0000_00F1, B=4 → result 0x1000_000F. done exactly 5 cycles after accept (STEP=1) or 2 (STEP=8). busy high 4 cycles / 1 cycle.
- SHRA A=0x8000_0000, B=40 → N saturates to 32 → result 0xFFFF_FFFF. SHR with the same inputs → 0x0000_0000.
- ROL A=0x8000_0001, B=33 → N=1 → result 0x0000_0003. B=32 → N=0 → result 0x8000_0001, done 1 cycle after accept.
- op=6, A=0x1234_5678 → done and illegal high together 1 cycle after accept, result 0x1234_5678.
- SHL A=1, B=31, start re-pulsed mid-SHIFT with A=0, B=0 → second start ignored, final result 0x8000_0000. Then a start in the DONE cycle is accepted back-to-back.
- SHR A=0xFFFF_FFFF, B=20, clear asserted 5 cycles after accept → next cycle state IDLE, result=0, busy=0, and done never pulses.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings, state enum and count helpers for the multi-cycle shift/rotate sequencer.
// Optional feature macro: SHIFT_MULTI_STEP_EN (STEP = 8 instead of 1).
package shift_pkg;

  localparam logic [2:0] OP_SHR  = 3'd0;
  localparam logic [2:0] OP_SHRA = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [5:0] MAX_SHIFT = 6'd32;

`ifdef SHIFT_MULTI_STEP_EN
  localparam logic [5:0] STEP = 6'd8;
`else
  localparam logic [5:0] STEP = 6'd1;
`endif

  function automatic logic op_is_illegal(input logic [2:0] op_i);
    return (op_i > OP_ROL);
  endfunction

  // Rotations wrap mod 32; shifts saturate at 32 over the full 32-bit amount.
  function automatic logic [5:0] sat_count(input logic [2:0] op_i, input logic [31:0] b_i);
    logic [5:0] n;
    case (op_i)
      OP_ROR, OP_ROL: n = {1'b0, b_i[4:0]};
      OP_SHR, OP_SHRA, OP_SHL: begin
        if (b_i > 32'd32) begin
          n = MAX_SHIFT;
        end else begin
          n = b_i[5:0];
        end
      end
      default: n = 6'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: applies a k-bit shift/rotate to value.
// With SHIFT_MULTI_STEP_EN k may be 1..8; otherwise only k = 1 (k = 0 passes through).
module shift_step
  import shift_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] value,
  input  logic [3:0]  k,
  output logic [31:0] value_out
);

`ifdef SHIFT_MULTI_STEP_EN
  logic [5:0] rev_amt;
  assign rev_amt = 6'd32 - {2'b00, k};

  // Variable-distance step; a k of 0 yields value unchanged for every op.
  always_comb begin
    case (op)
      OP_SHR:  value_out = value >> k;
      OP_SHRA: value_out = $unsigned($signed(value) >>> k);
      OP_SHL:  value_out = value << k;
      OP_ROR:  value_out = (value >> k) | (value << rev_amt);
      OP_ROL:  value_out = (value << k) | (value >> rev_amt);
      default: value_out = value;
    endcase
  end
`else
  // One-bit step.
  always_comb begin
    if (k == 4'd0) begin
      value_out = value;
    end else begin
      case (op)
        OP_SHR:  value_out = {1'b0, value[31:1]};
        OP_SHRA: value_out = {value[31], value[31:1]};
        OP_SHL:  value_out = {value[30:0], 1'b0};
        OP_ROR:  value_out = {value[0], value[31:1]};
        OP_ROL:  value_out = {value[30:0], value[31]};
        default: value_out = value;
      endcase
    end
  end
`endif

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller: IDLE -> SHIFT -> DONE, one step per clock.
// Latency depends on SHIFT_MULTI_STEP_EN (step of 8 bits instead of 1).
module shift_sequencer
  import shift_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        illegal
);

  state_t      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        illegal_q, illegal_d;

  logic [3:0]  k_s;
  logic [31:0] step_out_s;
  logic [5:0]  n_s;

  assign n_s = sat_count(op, B);

  // Step width for this edge: whatever remains, capped at STEP.
  always_comb begin
    if (count_q > STEP) begin
      k_s = STEP[3:0];
    end else begin
      k_s = count_q[3:0];
    end
  end

  shift_step u_step (
    .op        (op_q),
    .value     (result_q),
    .k         (k_s),
    .value_out (step_out_s)
  );

  // Next-state, count and result computation.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    result_d  = result_q;
    done_d    = 1'b0;
    busy_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          result_d = A;
          op_d     = op;
          count_d  = n_s;
          if (n_s == 6'd0) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            illegal_d = op_is_illegal(op);
          end else begin
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        result_d = step_out_s;
        count_d  = count_q - {2'b00, k_s};
        if (count_d == 6'd0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      count_q   <= 6'd0;
      op_q      <= 3'd0;
      result_q  <= 32'd0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      result_q  <= result_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      illegal_q <= illegal_d;
    end
  end

  assign ready   = ~busy_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer; expected latencies follow SHIFT_MULTI_STEP_EN.
module tb_shift_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        illegal;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SHIFT_MULTI_STEP_EN
  localparam int STEP = 8;
`else
  localparam int STEP = 1;
`endif

  shift_sequencer dut (
    .clock   (clock),
    .clear   (clear),
    .start   (start),
    .op      (op),
    .A       (A),
    .B       (B),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .illegal (illegal)
  );

  always #5 clock = ~clock;

  function automatic int exp_lat(input int n);
    if (n == 0) return 1;
    return ((n + STEP - 1) / STEP) + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, then count cycles to done; rp > 0 re-pulses start (SHL A=0 B=0) at that cycle.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int rp, output int lat, output int bc, output logic ill);
    @(negedge clock);
    check("ready_before_start", {31'd0, ready}, 32'd1);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clock); #1;
    start = 1'b0; op = 3'd5; A = 32'hDEAD_BEEF; B = 32'h0000_0007;
    lat = 0; bc = 0; ill = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (c == rp) begin
        start = 1'b1; op = 3'd2; A = 32'd0; B = 32'd0;
      end else begin
        start = 1'b0;
      end
      if (busy) bc++;
      if (done) begin
        lat = c;
        ill = illegal;
        break;
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
  endtask

  int   lat;
  int   bc;
  logic ill;
  int   pulses;
  int   clr_c;

  initial begin
    clear = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_result", result, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    clear = 1'b0;

    // ROR by 4
    do_op(3'd3, 32'h0000_00F1, 32'd4, 0, lat, bc, ill);
    check("ror4_result", result, 32'h1000_000F);
    check("ror4_lat", lat, exp_lat(4));
    check("ror4_busy", bc, exp_lat(4) - 1);
    check("ror4_illegal", {31'd0, ill}, 32'd0);
    @(posedge clock); #1;
    check("ror4_done_one_cycle", {31'd0, done}, 32'd0);
    check("ror4_hold", result, 32'h1000_000F);
    check("ror4_ready_idle", {31'd0, ready}, 32'd1);

    // Saturating shifts
    do_op(3'd1, 32'h8000_0000, 32'd40, 0, lat, bc, ill);
    check("shra40_result", result, 32'hFFFF_FFFF);
    check("shra40_lat", lat, exp_lat(32));
    do_op(3'd0, 32'h8000_0000, 32'd40, 0, lat, bc, ill);
    check("shr40_result", result, 32'h0000_0000);
    do_op(3'd2, 32'h0000_0001, 32'h1000_0000, 0, lat, bc, ill);
    check("shl_bigb_result", result, 32'h0000_0000);
    check("shl_bigb_lat", lat, exp_lat(32));

    // Rotate mod 32
    do_op(3'd4, 32'h8000_0001, 32'd33, 0, lat, bc, ill);
    check("rol33_result", result, 32'h0000_0003);
    check("rol33_lat", lat, exp_lat(1));
    do_op(3'd4, 32'h8000_0001, 32'd32, 0, lat, bc, ill);
    check("rol32_result", result, 32'h8000_0001);
    check("rol32_lat", lat, 1);
    check("rol32_busy", bc, 0);

    // Illegal op
    do_op(3'd6, 32'h1234_5678, 32'd5, 0, lat, bc, ill);
    check("illegal_result", result, 32'h1234_5678);
    check("illegal_lat", lat, 1);
    check("illegal_flag", {31'd0, ill}, 32'd1);
    @(posedge clock); #1;
    check("illegal_clears", {31'd0, illegal}, 32'd0);

    // SHL 31 with ignored re-start, then back-to-back accept in DONE cycle
    do_op(3'd2, 32'h0000_0001, 32'd31, 2, lat, bc, ill);
    check("shl31_result", result, 32'h8000_0000);
    check("shl31_lat", lat, exp_lat(31));
    do_op(3'd0, 32'h0000_00F0, 32'd4, 0, lat, bc, ill);
    check("b2b_result", result, 32'h0000_000F);
    check("b2b_lat", lat, exp_lat(4));

    // Clear mid-operation, with a simultaneous start that must be dropped
    clr_c = (STEP == 1) ? 5 : 2;
    pulses = 0;
    @(negedge clock);
    start = 1'b1; op = 3'd0; A = 32'hFFFF_FFFF; B = 32'd20;
    @(posedge clock); #1;
    start = 1'b0;
    for (int c = 1; c < clr_c; c++) begin
      if (done) pulses++;
      @(posedge clock); #1;
    end
    check("clr_busy_before", {31'd0, busy}, 32'd1);
    clear = 1'b1; start = 1'b1; op = 3'd2; A = 32'h0000_0055; B = 32'd3;
    @(posedge clock); #1;
    clear = 1'b0; start = 1'b0;
    check("clr_result", result, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_done", {31'd0, done}, 32'd0);
    check("clr_ready", {31'd0, ready}, 32'd1);
    for (int c = 0; c < 40; c++) begin
      if (done) pulses++;
      @(posedge clock); #1;
    end
    check("clr_no_done", pulses, 0);
    check("clr_result_stays", result, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
